// File: rtl/select_reg_scan.sv
// Select register with prioritised multi-source load, step, history restore
// and an automatic scan engine with masked compare and a sticky match flag.
module select_reg_scan #(
  parameter int ADDR_W     = 12,
  parameter int NSRC       = 4,
  parameter int HIST_DEPTH = 4,
  parameter int STEP       = 1
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [NSRC-1:0]                  load_req,
  input  logic [NSRC*ADDR_W-1:0]           load_data,
  input  logic                             step_req,
  input  logic                             restore_req,
  input  logic                             scan_start,
  input  logic [ADDR_W-1:0]                scan_end,
  input  logic                             stop_on_match,
  input  logic [ADDR_W-1:0]                cmp_value,
  input  logic [ADDR_W-1:0]                cmp_mask,
  input  logic                             match_clr,
  output logic [ADDR_W-1:0]                sel_value,
  output logic                             cmp_match,
  output logic                             match_sticky,
  output logic                             scan_busy,
  output logic                             scan_done,
  output logic [$clog2(HIST_DEPTH+1)-1:0]  hist_count
);

  localparam int HCW = $clog2(HIST_DEPTH+1);
  localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);
  localparam logic [HCW-1:0] HIST_FULL = HCW'(HIST_DEPTH);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] sel_nxt;
  logic [ADDR_W-1:0] load_val;
  logic              load_any;
  logic              push, pop, done_nxt;
  logic [ADDR_W-1:0] hist [HIST_DEPTH];

  assign cmp_match = ((sel_value ^ cmp_value) & cmp_mask) == '0;
  assign scan_busy = (state == SCAN);
  assign load_any  = |load_req;

  // Scanning from the top index down lets the lowest asserted source win.
  always_comb begin
    load_val = '0;
    for (int i = NSRC-1; i >= 0; i--) begin
      if (load_req[i]) load_val = load_data[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_value;
    push      = 1'b0;
    pop       = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (load_any) begin
          sel_nxt = load_val;
          push    = 1'b1;
        end else if (restore_req) begin
          if (hist_count != '0) begin
            sel_nxt = hist[0];
            pop     = 1'b1;
          end
        end else if (scan_start) begin
          push      = 1'b1;
          state_nxt = SCAN;
        end else if (step_req) begin
          sel_nxt = sel_value + STEP_V;
          push    = 1'b1;
        end
      end
      SCAN: begin
        // A load aborts the scan silently; no done pulse follows.
        if (load_any) begin
          sel_nxt   = load_val;
          push      = 1'b1;
          state_nxt = IDLE;
        end else if ((sel_value == scan_end) || (stop_on_match && cmp_match)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          sel_nxt = sel_value + STEP_V;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      sel_value    <= '0;
      hist_count   <= '0;
      match_sticky <= 1'b0;
      scan_done    <= 1'b0;
    end else begin
      state        <= state_nxt;
      sel_value    <= sel_nxt;
      scan_done    <= done_nxt;
      match_sticky <= (match_sticky & ~match_clr) | cmp_match;
      if (push && (hist_count != HIST_FULL)) hist_count <= hist_count + 1'b1;
      else if (pop) hist_count <= hist_count - 1'b1;
    end
  end

  // Entry 0 is the top of the LIFO; pushing when full drops the last entry.
  always_ff @(posedge clk) begin
    if (resetn && push) begin
      for (int i = HIST_DEPTH-1; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= sel_value;
    end else if (resetn && pop) begin
      for (int i = 0; i < HIST_DEPTH-1; i++) hist[i] <= hist[i+1];
    end
  end

endmodule
